// File: rtl/cp_demux_pkg.sv
// rtl/cp_demux_pkg.sv - shared defaults and channel index type for the 1-to-2 stream demux
package cp_demux_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 2;
  localparam int CNT_WIDTH_DEF  = 16;

  // Destination channel selector; one bit is enough for a 1-to-2 split.
  typedef logic chan_idx_t;

  localparam chan_idx_t CH0 = 1'b0;
  localparam chan_idx_t CH1 = 1'b1;

endpackage

// File: rtl/cp_demux_chan_fifo.sv
// rtl/cp_demux_chan_fifo.sv - per-channel synchronous FIFO with delivery counter
module cp_demux_chan_fifo
  import cp_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ready,
  output logic                  full,
  output logic                  empty,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_WIDTH-1:0]  cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic [DATA_WIDTH-1:0] last_head;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);
  assign valid = !empty;

  // A full FIFO refuses pushes even while popping: no bypass path.
  assign do_push = push && !full;
  assign do_pop  = !empty && ready;

  // While empty the head shows the last word that was visible (zero after reset).
  assign head = empty ? last_head : mem[rd_ptr];
  assign cnt  = cnt_q;

  // Storage array; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Remember the visible head so the output holds once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_head <= '0;
    end else if (!empty) begin
      last_head <= mem[rd_ptr];
    end
  end

  // Delivery counter wraps modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (do_pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cp_demux_1_to_2_stream_32b.sv
// rtl/cp_demux_1_to_2_stream_32b.sv - registered 1-to-2 stream demux with per-channel FIFOs
module cp_demux_1_to_2_stream_32b
  import cp_demux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_y0,
  output logic [DATA_WIDTH-1:0] o_y1,
  output logic                  o_valid0,
  output logic                  o_valid1,
  input  logic                  i_ready0,
  input  logic                  i_ready1,
  output logic [CNT_WIDTH-1:0]  o_cnt0,
  output logic [CNT_WIDTH-1:0]  o_cnt1
);

  chan_idx_t sel;
  logic      full0;
  logic      full1;
  logic      empty0;
  logic      empty1;
  logic      sel_full;
  logic      accept;
  logic      push0;
  logic      push1;

  assign sel = chan_idx_t'(i_sel);

  // Steering: readiness depends only on the disable and the selected FIFO's fullness,
  // never on i_valid or the consumer readies.
  always_comb begin
    sel_full = (sel == CH1) ? full1 : full0;
    o_ready  = !i_en && !sel_full;
    accept   = i_valid && o_ready;
    push0    = accept && (sel == CH0);
    push1    = accept && (sel == CH1);
  end

  cp_demux_chan_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chan0 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push0),
    .data  (i_data),
    .ready (i_ready0),
    .full  (full0),
    .empty (empty0),
    .valid (o_valid0),
    .head  (o_y0),
    .cnt   (o_cnt0)
  );

  cp_demux_chan_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chan1 (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push1),
    .data  (i_data),
    .ready (i_ready1),
    .full  (full1),
    .empty (empty1),
    .valid (o_valid1),
    .head  (o_y1),
    .cnt   (o_cnt1)
  );

endmodule

// File: tb/tb_cp_demux_1_to_2_stream_32b.sv
// tb/tb_cp_demux_1_to_2_stream_32b.sv - self-checking bench for the 1-to-2 stream demux
module tb_cp_demux_1_to_2_stream_32b;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, valid, sel, ready0, ready1;
  logic [DW-1:0] data;

  logic          o_ready, o_valid0, o_valid1;
  logic [DW-1:0] o_y0, o_y1;
  logic [CW-1:0] o_cnt0, o_cnt1;

  logic          s_ready, s_valid0, s_valid1;
  logic [DW-1:0] s_y0, s_y1;
  logic [3:0]    s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  cp_demux_1_to_2_stream_32b #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(o_ready),
    .i_sel(sel), .i_data(data), .o_y0(o_y0), .o_y1(o_y1), .o_valid0(o_valid0),
    .o_valid1(o_valid1), .i_ready0(ready0), .i_ready1(ready1), .o_cnt0(o_cnt0), .o_cnt1(o_cnt1)
  );

  cp_demux_1_to_2_stream_32b #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(s_ready),
    .i_sel(sel), .i_data(data), .o_y0(s_y0), .o_y1(s_y1), .o_valid0(s_valid0),
    .o_valid1(s_valid1), .i_ready0(ready0), .i_ready1(ready1), .o_cnt0(s_cnt0), .o_cnt1(s_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int unsigned   m_cnt0, m_cnt1;
  logic [DW-1:0] last_y0, last_y1;

  typedef struct {
    logic          en, valid, sel;
    logic [DW-1:0] data;
    logic          r0, r1;
    logic          e_ready, e_v0, e_v1;
    logic [DW-1:0] e_y0, e_y1;
    logic [CW-1:0] e_c0, e_c1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0  = 0;
    m_cnt1  = 0;
    last_y0 = '0;
    last_y1 = '0;
  endtask

  task automatic check_outputs();
    check("valid0", o_valid0, q0.size() != 0);
    check("valid1", o_valid1, q1.size() != 0);
    check("y0", o_y0, (q0.size() != 0) ? q0[0] : last_y0);
    check("y1", o_y1, (q1.size() != 0) ? q1[0] : last_y1);
    check("cnt0", o_cnt0, CW'(m_cnt0));
    check("cnt1", o_cnt1, CW'(m_cnt1));
    check("cnt0_w4", s_cnt0, 4'(m_cnt0));
    check("cnt1_w4", s_cnt1, 4'(m_cnt1));
  endtask

  // One clock of stimulus already on the inputs, checked against the queue model.
  task automatic step();
    logic          exp_ready, acc, p0, p1, s;
    logic [DW-1:0] d;
    #1;
    exp_ready = !en && ((sel ? q1.size() : q0.size()) < DEPTH);
    check("o_ready", o_ready, exp_ready);
    acc = valid && exp_ready;
    s   = sel;
    d   = data;
    p0  = (q0.size() != 0) && ready0;
    p1  = (q1.size() != 0) && ready1;
    @(posedge clk);
    if (p0) begin last_y0 = q0.pop_front(); m_cnt0++; end
    if (p1) begin last_y1 = q1.pop_front(); m_cnt1++; end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic randomize_inputs();
    en     = 1'($urandom_range(0, 7) == 0);
    valid  = 1'($urandom);
    sel    = 1'($urandom);
    data   = $urandom;
    ready0 = 1'($urandom_range(0, 3) != 0);
    ready1 = 1'($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    randomize_inputs();
    #1;
    check("rst_async_valid0", o_valid0, 1'b0);
    check("rst_async_cnt0", o_cnt0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      #1;
      check("rst_valid0", o_valid0, 1'b0);
      check("rst_valid1", o_valid1, 1'b0);
      check("rst_y0", o_y0, '0);
      check("rst_y1", o_y1, '0);
      check("rst_cnt0", o_cnt0, '0);
      check("rst_cnt1", o_cnt1, '0);
    end
    @(negedge clk);
    en    = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_release_ready", o_ready, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    valid  = 1'b0;
    sel    = 1'b0;
    data   = '0;
    ready0 = 1'b0;
    ready1 = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0,          16'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002, 16'd1, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 16'd1, 16'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'hA5A5_0003, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5_0003, 32'h0000_0002, 16'd1, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h5A5A_0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5_0003, 32'h0000_0002, 16'd1, 16'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hDEAD_0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0003, 32'h0000_0002, 16'd1, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'hBEEF_0006, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0003, 32'hBEEF_0006, 16'd1, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'hDEAD_0005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5A5A_0004, 32'hBEEF_0006, 16'd2, 16'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'hDEAD_0005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_0005, 32'hBEEF_0006, 16'd3, 16'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0005, 32'hBEEF_0006, 16'd4, 16'd2};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0005, 32'hBEEF_0006, 16'd4, 16'd2};

    // Directed table: routing, backpressure isolation, full-with-pop, disable.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      en     = vecs[i].en;
      valid  = vecs[i].valid;
      sel    = vecs[i].sel;
      data   = vecs[i].data;
      ready0 = vecs[i].r0;
      ready1 = vecs[i].r1;
      #1;
      check($sformatf("vec%0d_ready", i), o_ready, vecs[i].e_ready);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid0", i), o_valid0, vecs[i].e_v0);
      check($sformatf("vec%0d_valid1", i), o_valid1, vecs[i].e_v1);
      check($sformatf("vec%0d_y0", i), o_y0, vecs[i].e_y0);
      check($sformatf("vec%0d_y1", i), o_y1, vecs[i].e_y1);
      check($sformatf("vec%0d_cnt0", i), o_cnt0, vecs[i].e_c0);
      check($sformatf("vec%0d_cnt1", i), o_cnt1, vecs[i].e_c1);
    end

    // Disable: buffered words keep draining while nothing is accepted.
    do_reset();
    ready0 = 1'b0;
    ready1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'b0; valid = 1'b1; sel = 1'b0; data = $urandom;
      step();
    end
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; valid = 1'b1; sel = 1'($urandom); data = $urandom;
      ready0 = (i >= 2); ready1 = 1'b1;
      step();
    end
    check("disable_cnt0", o_cnt0, 16'd2);
    check("disable_cnt1", o_cnt1, 16'd0);

    // Counter wrap on the 4-bit build: 17 deliveries on channel 1.
    do_reset();
    ready0 = 1'b0;
    ready1 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      en = 1'b0; valid = 1'b1; sel = 1'b1; data = $urandom;
      step();
    end
    valid = 1'b0;
    step();
    step();
    check("wrap_cnt1_w4", s_cnt1, 4'd1);
    check("wrap_cnt1_w16", o_cnt1, 16'd17);

    // Randomized traffic against the queue model, with a reset mid-stream.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      randomize_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
